// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity and stop codes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b011,
        ST_PARITY = 3'b010,
        ST_STOP   = 3'b110
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic [1:0] STOP_ONE = 2'b00;
    localparam logic [1:0] STOP_TWO = 2'b10;

    function automatic logic par_en(input logic [1:0] p);
        return (p == PAR_ODD) || (p == PAR_EVEN);
    endfunction

    function automatic logic two_stop(input logic [1:0] s);
        return (s & STOP_TWO) != STOP_ONE;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit sampling counter and bit sampler.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around the sample point.
module uart_rx_sampler #(
    parameter int SAMPLING = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic s_data_in,
    input  logic clr,
    input  logic half,
    output logic line,
    output logic bit_sample,
    output logic bit_strobe
);

    localparam int CW = $clog2(SAMPLING);
    localparam logic [CW-1:0] LAST = CW'(SAMPLING - 1);
    localparam logic [CW-1:0] MID  = CW'(SAMPLING / 2 - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], s_data_in};
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (sample_tick) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign line       = sync_q[1];
    assign bit_strobe = sample_tick && (cnt_q == (half ? MID : LAST));

`ifdef UART_RX_MAJORITY_EN
    // Line values from the two ticks preceding the sample point
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (sample_tick) begin
            hist_d = {hist_q[0], line};
        end
    end

    assign bit_sample = (hist_q[1] & hist_q[0]) |
                        (hist_q[1] & line) |
                        (hist_q[0] & line);

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign bit_sample = line;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_control.sv
// UART receiver: start/data/parity/stop framing FSM with status outputs.
// Define UART_RX_MAJORITY_EN to enable majority-vote bit sampling.
module uart_rx_control
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SAMPLING   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  s_data_in,
    input  logic [1:0]            parity,
    input  logic [1:0]            stop,
    output logic [DATA_WIDTH-1:0] p_data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]            par_cfg_q, par_cfg_d;
    logic [1:0]            stop_cfg_q, stop_cfg_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dv_q, dv_d;
    logic                  perr_out_q, perr_out_d;
    logic                  ferr_out_q, ferr_out_d;

    logic line, bit_sample, bit_strobe, clr, exp_par;

    uart_rx_sampler #(
        .SAMPLING(SAMPLING)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .s_data_in  (s_data_in),
        .clr        (clr),
        .half       (state_q == ST_START),
        .line       (line),
        .bit_sample (bit_sample),
        .bit_strobe (bit_strobe)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_cfg_d  = par_cfg_q;
        stop_cfg_d = stop_cfg_q;
        stop_cnt_d = stop_cnt_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        dout_d     = dout_q;
        dv_d       = 1'b0;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        exp_par    = (par_cfg_q == PAR_EVEN) ? ^shift_q : ~^shift_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sample_tick && !line) begin
                    state_d    = ST_START;
                    par_cfg_d  = parity;
                    stop_cfg_d = stop;
                end
            end
            ST_START: begin
                if (bit_strobe) begin
                    if (bit_sample) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (bit_strobe) begin
                    shift_d   = {bit_sample, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = par_en(par_cfg_q) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_strobe) begin
                    perr_d  = (bit_sample != exp_par);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_strobe) begin
                    ferr_d = ferr_q | ~bit_sample;
                    if (two_stop(stop_cfg_q) && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        dout_d     = shift_q;
                        perr_out_d = perr_q;
                        ferr_out_d = ferr_q | ~bit_sample;
                        dv_d       = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Counter restarts on every state entry and stays cleared while idle
        clr = (state_q == ST_IDLE) || (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_cfg_q  <= PAR_NONE;
            stop_cfg_q <= STOP_ONE;
            stop_cnt_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            dout_q     <= '0;
            dv_q       <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_cfg_q  <= par_cfg_d;
            stop_cfg_q <= stop_cfg_d;
            stop_cnt_q <= stop_cnt_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            dout_q     <= dout_d;
            dv_q       <= dv_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
        end
    end

    assign p_data_out = dout_q;
    assign data_valid = dv_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_control.sv
// Directed testbench for uart_rx_control (SAMPLING=16, tick every 4 clk).
// Glitch expectation follows UART_RX_MAJORITY_EN.
module tb_uart_rx_control;

    logic       clk;
    logic       reset;
    logic       sample_tick;
    logic       s_data_in;
    logic [1:0] parity;
    logic [1:0] stop;
    logic [7:0] p_data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int   total, bad, ncnt, dv_cnt, dv_dbl, n0;
    logic dv_prev;
    time  t0, dv_time;

    logic [7:0] rst_dout;
    logic       rst_dv, rst_pe, rst_fe, rst_busy;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] EXP_GL = 8'h00;
`else
    localparam logic [7:0] EXP_GL = 8'h08;
`endif

    uart_rx_control dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .s_data_in  (s_data_in),
        .parity     (parity),
        .stop       (stop),
        .p_data_out (p_data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        dv_cnt  = 0;
        dv_dbl  = 0;
        dv_prev = 1'b0;
        dv_time = 0;
        forever begin
            @(negedge clk);
            if (data_valid === 1'b1) begin
                dv_cnt++;
                dv_time = $time;
                if (dv_prev) dv_dbl++;
            end
            dv_prev = (data_valid === 1'b1);
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks; inputs change on the falling edge, tick every 4th clk
    task automatic clk_n(input int n);
        repeat (n) begin
            @(negedge clk);
            ncnt++;
            sample_tick = (ncnt % 4 == 0);
        end
    endtask

    task automatic align();
        while (ncnt % 4 != 2) clk_n(1);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pb_en,
                              input logic pb, input int nstop,
                              input logic [1:0] stopv, input int glitch_bit,
                              input int rst_bit, input int chg_bit);
        align();
        t0 = $time;
        s_data_in = 1'b0;
        clk_n(64);
        for (int k = 0; k < 8; k++) begin
            s_data_in = d[k];
            if (k == chg_bit) begin
                parity = 2'b10;
                stop   = 2'b10;
            end
            if (k == glitch_bit) begin
                clk_n(32);
                s_data_in = 1'b1;
                clk_n(4);
                s_data_in = d[k];
                clk_n(28);
            end else if (k == rst_bit) begin
                clk_n(32);
                reset = 1'b1;
                clk_n(1);
                reset    = 1'b0;
                rst_dout = p_data_out;
                rst_dv   = data_valid;
                rst_pe   = parity_err;
                rst_fe   = frame_err;
                rst_busy = busy;
                clk_n(31);
            end else begin
                clk_n(64);
            end
        end
        if (pb_en) begin
            s_data_in = pb;
            clk_n(64);
        end
        for (int j = 0; j < nstop; j++) begin
            s_data_in = stopv[j];
            clk_n(64);
        end
        s_data_in = 1'b1;
        clk_n(128);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        ncnt        = 0;
        reset       = 1'b1;
        sample_tick = 1'b0;
        s_data_in   = 1'b1;
        parity      = 2'b00;
        stop        = 2'b00;
        clk_n(4);
        reset = 1'b0;
        clk_n(1);

        check("rst_dout", p_data_out, 8'h00);
        check("rst_dv", data_valid, 1'b0);
        check("rst_pe", parity_err, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);

        // 8N1 clean frame
        n0 = dv_cnt;
        send_frame(8'hA5, 0, 1'b0, 1, 2'b11, -1, -1, -1);
        check("a5_cnt", dv_cnt - n0, 1);
        check("a5_dout", p_data_out, 8'hA5);
        check("a5_pe", parity_err, 1'b0);
        check("a5_fe", frame_err, 1'b0);
        check("a5_busy", busy, 1'b0);
        check("a5_lat", (dv_time - t0 >= 6070) && (dv_time - t0 <= 6150), 1'b1);

        // Even parity: 0x37 has five ones, so the parity bit must be 1
        parity = 2'b10;
        n0 = dv_cnt;
        send_frame(8'h37, 1, 1'b0, 1, 2'b11, -1, -1, -1);
        check("ev0_cnt", dv_cnt - n0, 1);
        check("ev0_dout", p_data_out, 8'h37);
        check("ev0_pe", parity_err, 1'b1);
        send_frame(8'h37, 1, 1'b1, 1, 2'b11, -1, -1, -1);
        check("ev1_pe", parity_err, 1'b0);

        // Odd parity: expected bit for 0x37 is 0
        parity = 2'b01;
        send_frame(8'h37, 1, 1'b0, 1, 2'b11, -1, -1, -1);
        check("od0_pe", parity_err, 1'b0);
        send_frame(8'h37, 1, 1'b1, 1, 2'b11, -1, -1, -1);
        check("od1_pe", parity_err, 1'b1);

        // Two stop bits, second one low
        parity = 2'b00;
        stop   = 2'b10;
        n0 = dv_cnt;
        send_frame(8'h3C, 0, 1'b0, 2, 2'b01, -1, -1, -1);
        check("fe_cnt", dv_cnt - n0, 1);
        check("fe_dout", p_data_out, 8'h3C);
        check("fe_fe", frame_err, 1'b1);
        send_frame(8'h96, 0, 1'b0, 2, 2'b11, -1, -1, -1);
        check("ok2_dout", p_data_out, 8'h96);
        check("ok2_fe", frame_err, 1'b0);

        // False start: 4 ticks low
        stop = 2'b00;
        n0 = dv_cnt;
        align();
        s_data_in = 1'b0;
        clk_n(16);
        check("fs_busy_hi", busy, 1'b1);
        s_data_in = 1'b1;
        clk_n(24);
        check("fs_busy_lo", busy, 1'b0);
        clk_n(64);
        check("fs_cnt", dv_cnt - n0, 0);

        // Config inputs change mid-frame; the latched 8N1 must stand
        n0 = dv_cnt;
        send_frame(8'h5A, 0, 1'b0, 1, 2'b11, -1, -1, 2);
        check("cfg_cnt", dv_cnt - n0, 1);
        check("cfg_dout", p_data_out, 8'h5A);
        check("cfg_pe", parity_err, 1'b0);
        parity = 2'b00;
        stop   = 2'b00;

        // Reset during data bit 4; remaining bits of 0xF5 are all 1
        n0 = dv_cnt;
        send_frame(8'hF5, 0, 1'b0, 1, 2'b11, -1, 4, -1);
        check("mr_dout", rst_dout, 8'h00);
        check("mr_dv", rst_dv, 1'b0);
        check("mr_pe", rst_pe, 1'b0);
        check("mr_fe", rst_fe, 1'b0);
        check("mr_busy", rst_busy, 1'b0);
        check("mr_cnt", dv_cnt - n0, 0);
        check("mr_outd", p_data_out, 8'h00);
        send_frame(8'h81, 0, 1'b0, 1, 2'b11, -1, -1, -1);
        check("nx_cnt", dv_cnt - n0, 1);
        check("nx_dout", p_data_out, 8'h81);

        // One-tick high glitch at the bit 3 sample point
        send_frame(8'h00, 0, 1'b0, 1, 2'b11, 3, -1, -1);
        check("gl_dout", p_data_out, EXP_GL);

        check("dv_double", dv_dbl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_control.md
# uart_rx_control

Serial-to-parallel receiver for the UART. It consumes the serial line that `tx_control` drives and recovers each frame: start bit, `DATA_WIDTH` data bits LSB first, optional parity bit, and one or two stop bits. All timing derives from a `SAMPLING`× baud tick enable. Each received word is delivered as a single-cycle `data_valid` pulse with parity and framing status attached.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `SAMPLING`, default 16: `sample_tick` pulses per bit. Must be ≥ 4 and even.
- `clk` input 1: the only clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `sample_tick` input 1: one-`clk`-wide enable at `SAMPLING`× baud.
- `s_data_in` input 1: asynchronous serial line; idles high.
- `parity` input 2: 00 = none, 01 = odd, 10 = even, 11 = none.
- `stop` input 2: 00 or 01 = one stop bit, 10 or 11 = two stop bits.
- `p_data_out` output `DATA_WIDTH`: last received word.
- `data_valid` output 1: one-`clk` pulse when `p_data_out` is updated.
- `parity_err` output 1: parity mismatch in the last word.
- `frame_err` output 1: a stop-bit sample of the last word was 0.
- `busy` output 1: high in every state except IDLE.

## Operation
- **Input synchronizer:** two flops on `s_data_in`, both reset to 1. Every reference to "line" below means the synchronized value.
- **State machine:** IDLE, START, DATA, PARITY, STOP.
- **Tick gating:** counters advance only on cycles where `sample_tick` = 1. All sampling decisions are evaluated on tick cycles.
- **Sampling counter:** width $clog2(SAMPLING). It resets to 0 on every state entry.
- **IDLE → START:** on a tick where the line is 0. At the same point, `parity` and `stop` are latched and held for the whole frame.
- **START:** when the counter reaches SAMPLING/2−1, the line is sampled.
  - Sample = 1: false start, return to IDLE.
  - Sample = 0: go to DATA. The start bit is sampled at mid-bit, so every later bit is sampled at counter = SAMPLING−1.
- **DATA:** bit counter width $clog2(DATA_WIDTH+1).
  - Each bit-sample shifts the sampled value into the shift register from the MSB side, so the result is LSB-first.
  - After `DATA_WIDTH` samples, go to PARITY if the latched parity is 01 or 10; otherwise go to STOP.
- **PARITY:** one bit-sample.
  - Expected bit = ^data for even parity, ~^data for odd parity.
  - A mismatch sets the internal error flag.
- **STOP:** one or two bit-samples. Any 0 sample sets the internal framing flag.
- **Frame end:** after the last stop sample, on the same `clk` edge:
  - `p_data_out`, `parity_err` and `frame_err` are loaded.
  - `data_valid` goes to 1 for one cycle.
  - The state returns to IDLE, at mid-stop-bit.
- **Framing error:** a frame with a framing error is still delivered; `frame_err` = 1.
- **Output hold:** `p_data_out`, `parity_err` and `frame_err` hold until the next `data_valid`.
- **Reset values:** `p_data_out` = 0, `data_valid` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0, state = IDLE.

## Timing
- **Line to IDLE exit:** 2 `clk` synchronizer latency, plus the first tick that sees 0.
- **Start to `data_valid`:** the line falling is followed by `data_valid` after (1 + `DATA_WIDTH` + P + S − 0.5)·`SAMPLING` ticks, ±1 tick, plus 2 `clk`. P is 0 or 1 for the parity bit; S is the number of stop bits.
- **`data_valid` timing:** asserted on the `clk` following the final stop sample edge. Never asserted on two consecutive cycles.
- **Reset mid-frame:** the partial word is discarded, no `data_valid` is produced, and the next cycle is IDLE.
- **`sample_tick` stuck low:** all counters and the state hold indefinitely.
- **Back-to-back frames:** a start bit arriving immediately after the stop bit is detected with no lost frame.
- **Config changes mid-frame:** a change on `parity` or `stop` during a frame has no effect until the next frame.

## Configuration
- **`UART_RX_MAJORITY_EN` defined:** each sample is the 2-of-3 majority of the line at counter values N−2, N−1 and N, where N is the sample point.
- **`UART_RX_MAJORITY_EN` undefined:** each sample is the single line value at counter = N.

## Structure
- **Shared package `uart_pkg`:**
  - state encoding constants (Gray: IDLE 000, START 001, DATA 011, PARITY 010, STOP 110);
  - parity codes PAR_NONE, PAR_ODD, PAR_EVEN;
  - stop codes.
- **Sub-module `uart_rx_sampler`:** contains the synchronizer, the sampling counter, and the majority logic. It outputs `bit_sample` and `bit_strobe` to the FSM.

## Test plan
- **Clean frame:** 0xA5, no parity, 1 stop → one `data_valid`; `p_data_out` = 0xA5, `parity_err` = 0, `frame_err` = 0; `busy` low afterwards.
- **Parity error:** even parity, 0x37 sent with parity bit 0 → `p_data_out` = 0x37, `parity_err` = 1. The same word with parity bit 1 gives `parity_err` = 0.
- **False start:** line low for 4 ticks, then high → no `data_valid`; `busy` returns to 0 by tick 8.
- **Framing error:** 2 stop bits, 0x3C with the second stop bit = 0 → `p_data_out` = 0x3C, `frame_err` = 1.
- **Reset mid-frame:** `reset` pulsed during data bit 4 → no `data_valid`; all outputs 0. The next 0x81 frame is received correctly.
- **Glitch rejection:** a 1-tick high glitch at the sample point of data bit 3 of 0x00.
  - With `UART_RX_MAJORITY_EN`: `p_data_out` = 0x00.
  - Without it: `p_data_out` = 0x08.
